// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: buffers operand pairs, streams them into the 2-bit MAC,
// waits for the MAC pipeline to settle and offers the accumulator on a result port.
// Optional build macro MAC_SEQ_CHECK_EN adds a shadow sum that flags a MAC mismatch
// on res_err; without it res_err is tied low.
module mac_operand_sequencer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ACC_W      = 8,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_a,
    input  logic [1:0]                 in_b,
    input  logic                       start,
    output logic [1:0]                 mac_a,
    output logic [1:0]                 mac_b,
    output logic                       mac_run,
    output logic                       mac_reset,
    input  logic [ACC_W-1:0]           mac_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ACC_W-1:0]           res_data,
    output logic                       res_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {StIdle, StClear, StIssue, StSettle, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [1:0]       mac_a_q, mac_a_d;
    logic [1:0]       mac_b_q, mac_b_d;
    logic             mac_run_q, mac_run_d;
    logic             mac_reset_q, mac_reset_d;
    logic             res_valid_q, res_valid_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    logic             buf_we;
    logic [3:0]       pair_buf_q [DEPTH];

    assign in_ready  = (state_q == StIdle) && (count_q < DEPTH_C) && !start;
    assign busy      = (state_q != StIdle);
    assign count     = count_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_run   = mac_run_q;
    assign mac_reset = mac_reset_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    // Next state plus the registered MAC/result outputs for the state being entered.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        mac_a_d     = 2'd0;
        mac_b_d     = 2'd0;
        mac_run_d   = 1'b0;
        mac_reset_d = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        buf_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // in_ready is low while start is high, so load and start never coincide
                if (in_valid && in_ready) begin
                    buf_we  = 1'b1;
                    count_d = count_q + 1'b1;
                end
                if (start && (count_q != '0)) begin
                    state_d     = StClear;
                    mac_reset_d = 1'b1;
                    idx_d       = '0;
                end
            end
            StClear: begin
                state_d            = StIssue;
                mac_run_d          = 1'b1;
                {mac_a_d, mac_b_d} = pair_buf_q[0];
                idx_d              = {{(CW-1){1'b0}}, 1'b1};
            end
            StIssue: begin
                // idx points at the next pair; the current one is already on mac_a/mac_b
                if (idx_q < count_q) begin
                    mac_run_d          = 1'b1;
                    {mac_a_d, mac_b_d} = pair_buf_q[idx_q[IW-1:0]];
                    idx_d              = idx_q + 1'b1;
                end else begin
                    state_d  = StSettle;
                    settle_d = '0;
                end
            end
            StSettle: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d     = StDone;
                    res_valid_d = 1'b1;
                    res_data_d  = mac_out;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d     = StIdle;
                    res_valid_d = 1'b0;
                    count_d     = '0;
                    idx_d       = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            idx_q       <= '0;
            settle_q    <= '0;
            mac_a_q     <= 2'd0;
            mac_b_q     <= 2'd0;
            mac_run_q   <= 1'b0;
            mac_reset_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_run_q   <= mac_run_d;
            mac_reset_q <= mac_reset_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // Operand buffer; contents are don't-care after reset so it has none.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            pair_buf_q[count_q[IW-1:0]] <= {in_a, in_b};
        end
    end

`ifdef MAC_SEQ_CHECK_EN
    logic [ACC_W-1:0] shadow_q, shadow_d;
    logic             res_err_q, res_err_d;
    logic [3:0]       issue_prod;

    assign issue_prod = {2'b00, mac_a_q} * {2'b00, mac_b_q};
    assign res_err    = res_err_q;

    // Shadow sum of what was actually driven to the MAC, compared at capture.
    always_comb begin
        shadow_d  = shadow_q;
        res_err_d = res_err_q;
        if (state_q == StClear) begin
            shadow_d = '0;
        end else if (state_q == StIssue) begin
            shadow_d = shadow_q + ACC_W'(issue_prod);
        end
        if ((state_q == StSettle) && (settle_q == SETTLE_LAST)) begin
            res_err_d = (mac_out != shadow_q);
        end
        if ((state_q == StDone) && res_ready) begin
            res_err_d = 1'b0;
        end
    end

    // Shadow and error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q  <= '0;
            res_err_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            res_err_q <= res_err_d;
        end
    end
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer with an attached behavioural MAC.
// Build with MAC_SEQ_CHECK_EN defined to exercise the res_err self-check.
module tb_mac_operand_sequencer;

    localparam int DEPTH = 8;
    localparam int ACC_W = 8;
    localparam int S     = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset, in_valid, start, res_ready;
    logic [1:0]       in_a, in_b;
    logic             in_ready, mac_run, mac_reset, res_valid, res_err, busy;
    logic [1:0]       mac_a, mac_b;
    logic [ACC_W-1:0] mac_out, res_data;
    logic [CW-1:0]    count;

    // Behavioural MAC: product register then accumulator (two-cycle latency).
    logic [ACC_W-1:0] acc;
    logic [3:0]       prod;
    bit               force_en = 1'b0;
    logic [ACC_W-1:0] force_val = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit armed    = 1'b0;

    always #5 clk = ~clk;

    mac_operand_sequencer #(.DEPTH(DEPTH), .ACC_W(ACC_W), .SETTLE_CYC(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .start    (start),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_run  (mac_run),
        .mac_reset(mac_reset),
        .mac_out  (mac_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_err  (res_err),
        .busy     (busy),
        .count    (count)
    );

    assign mac_out = force_en ? force_val : acc;

    always @(posedge clk) begin
        if (reset || mac_reset) begin
            acc  <= '0;
            prod <= '0;
        end else begin
            prod <= mac_run ? ({2'b00, mac_a} * {2'b00, mac_b}) : 4'd0;
            acc  <= acc + ACC_W'(prod);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: a queue of loaded pairs plus the edge at which start was taken.
    // Relative to that edge: cycle 0 clears, cycles 1..n issue q[0..n-1], result
    // appears at cycle n+S+1 and is held until the consumer takes it.
    bit [3:0]         mq[$];
    bit               m_run  = 1'b0;
    bit               m_done = 1'b0;
    int               t0 = 0;
    int               mn = 0;
    logic [ACC_W-1:0] m_sum  = '0;
    logic [ACC_W-1:0] m_data = '0;
    bit               m_err  = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            mq.delete();
            m_run  = 1'b0;
            m_done = 1'b0;
            m_data = '0;
            m_err  = 1'b0;
        end else if (m_run) begin
            if (cyc - t0 == mn + S + 1) begin
                m_data = force_en ? force_val : m_sum;
`ifdef MAC_SEQ_CHECK_EN
                m_err = (m_data != m_sum);
`endif
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end else if (m_done) begin
            if (res_ready) begin
                m_done = 1'b0;
                m_err  = 1'b0;
                mq.delete();
            end
        end else begin
            if (start && mq.size() > 0) begin
                m_run = 1'b1;
                t0    = cyc;
                mn    = mq.size();
                m_sum = '0;
                foreach (mq[i]) m_sum = m_sum + ACC_W'(mq[i][3:2] * mq[i][1:0]);
            end else if (in_valid && !start && mq.size() < DEPTH) begin
                mq.push_back({in_a, in_b});
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    int         rel;
    logic       e_run;
    logic [3:0] e_ab;
    always @(negedge clk) begin
        if (armed) begin
            rel   = cyc - t0;
            e_run = m_run && rel >= 1 && rel <= mn;
            e_ab  = 4'd0;
            if (e_run) e_ab = mq[rel-1];
            chk("busy", busy, m_run || m_done);
            chk("count", count, mq.size());
            chk("in_ready", in_ready, !m_run && !m_done && mq.size() < DEPTH && !start);
            chk("mac_reset", mac_reset, m_run && rel == 0);
            chk("mac_run", mac_run, e_run);
            chk("mac_ab", {mac_a, mac_b}, e_ab);
            chk("res_valid", res_valid, m_done);
            chk("res_err", res_err, m_err);
            if (m_done) chk("res_data", res_data, m_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_res(output int k);
        k = 0;
        while (!res_valid && k < 50) begin
            tick();
            k++;
        end
        chk("res_wait_bound", res_valid, 1'b1);
    endtask

    task automatic take();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    int k;

    initial begin
        reset = 1'b1; in_valid = 1'b0; start = 1'b0; res_ready = 1'b0;
        in_a = 2'd0; in_b = 2'd0;

        // 1: reset state
        tick();
        armed = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_mac_run", mac_run, 0);
        chk("rst_mac_reset", mac_reset, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_res_data", res_data, 0);
        reset = 1'b0;

        // 2: three pairs, 3*2+1*1+2*3 = 13
        load(2'd3, 2'd2); load(2'd1, 2'd1); load(2'd2, 2'd3);
        do_start();
        chk("t2_clear", {mac_reset, mac_run}, 2'b10);
        tick(); chk("t2_issue0", {mac_run, mac_a, mac_b}, {1'b1, 2'd3, 2'd2});
        tick(); chk("t2_issue1", {mac_run, mac_a, mac_b}, {1'b1, 2'd1, 2'd1});
        tick(); chk("t2_issue2", {mac_run, mac_a, mac_b}, {1'b1, 2'd2, 2'd3});
        tick(); chk("t2_settle", mac_run, 0);
        wait_res(k);
        chk("t2_latency", k, 2);
        chk("t2_data", res_data, 13);
        take();

        // 3: full buffer of (3,3), 8*9 = 72
        for (int i = 0; i < DEPTH; i++) load(2'd3, 2'd3);
        chk("t3_count_full", count, 8);
        in_valid = 1'b1;
        #1 chk("t3_full_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        chk("t3_count_hold", count, 8);
        do_start();
        wait_res(k);
        chk("t3_data", res_data, 72);
        take();

        // 4: start with empty buffer, in_valid alongside start
        start = 1'b1; in_valid = 1'b1; in_a = 2'd1; in_b = 2'd1;
        #1 chk("t4_ready_low", in_ready, 0);
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_no_clear", mac_reset, 0);
        chk("t4_count", count, 0);

        // 5: reset during the second issue cycle
        load(2'd1, 2'd1); load(2'd2, 2'd2);
        do_start();
        tick(); tick();
        chk("t5_second_issue", {mac_run, mac_a, mac_b}, {1'b1, 2'd2, 2'd2});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_count", count, 0);
        chk("t5_run", mac_run, 0);
        chk("t5_valid", res_valid, 0);
        load(2'd1, 2'd2);
        do_start();
        wait_res(k);
        chk("t5_data", res_data, 2);
        take();

        // 6: result held under backpressure; forced MAC value
        load(2'd1, 2'd1);
        force_en = 1'b1; force_val = 8'd5;
        do_start();
        wait_res(k);
        start = 1'b1; in_valid = 1'b1;
        repeat (5) tick();
        chk("t6_hold_valid", res_valid, 1);
        chk("t6_hold_data", res_data, 5);
        chk("t6_hold_count", count, 1);
`ifdef MAC_SEQ_CHECK_EN
        chk("t6_err_forced", res_err, 1);
`else
        chk("t6_err_forced", res_err, 0);
`endif
        start = 1'b0; in_valid = 1'b0;
        take();
        force_en = 1'b0;
        chk("t6_err_cleared", res_err, 0);
        load(2'd1, 2'd1);
        do_start();
        wait_res(k);
        chk("t6_data", res_data, 1);
        chk("t6_err_clean", res_err, 0);
        take();

        // Random traffic, including mid-run resets and backpressure.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            in_a      = 2'($urandom_range(3, 0));
            in_b      = 2'($urandom_range(3, 0));
            start     = ($urandom_range(5, 0) == 0);
            res_ready = ($urandom_range(2, 0) == 0);
            reset     = ($urandom_range(199, 0) == 0);
            tick();
        end
        in_valid = 1'b0; start = 1'b0; res_ready = 1'b0; reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
